// File: rtl/mmc1_serial_writer.sv
`timescale 1ns/1ps
// mmc1_serial_writer
//   Bus master for the MMC1 serial-load port. It loads a 5-bit value into
//   one of the four mapper registers. Each write carries one data bit
//   (LSB first) on D0, and the mapper latches it on the rising edge of
//   romsel. An optional leading write of 8'h80 first clears the mapper's
//   shift register.
//
//   Handshake: a command is accepted on a rising m2 edge where start=1
//   while the block is idle. busy is high from the next cycle until the
//   sequence ends. done pulses for one cycle with busy=0, and a start in
//   that cycle is accepted. Inputs are ignored while busy is high.
//
// Ports
//   m2            in   system clock, posedge
//   reset_n       in   synchronous active-low reset
//   start         in   command strobe, sampled only while idle
//   reg_sel[1:0]  in   0 control, 1 chr0, 2 chr1, 3 prg
//   value[4:0]    in   register value to load
//   do_reset      in   prefix the sequence with a shift-register reset write
//   busy          out  sequence in progress
//   done          out  one-cycle completion pulse
//   romsel_out    out  active-low ROM select strobe
//   cpu_rw_out    out  1 read/idle, 0 write
//   cpu_addr_out  out  CPU A14..A0
//   cpu_data_out  out  CPU D7..D0
module mmc1_serial_writer #(
   parameter int unsigned STROBE_LEN = 2,
   parameter int unsigned GAP_LEN    = 2,
   parameter logic [12:0] ADDR_LOW   = 13'h0000
) (
   input  logic        m2,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  reg_sel,
   input  logic [4:0]  value,
   input  logic        do_reset,
   output logic        busy,
   output logic        done,
   output logic        romsel_out,
   output logic        cpu_rw_out,
   output logic [14:0] cpu_addr_out,
   output logic [7:0]  cpu_data_out
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;

   localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN - 1);
   localparam logic [3:0] GAP_LAST    = 4'(GAP_LEN - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;          // cycles spent in STROBE or GAP
   logic [2:0]  idx_q, idx_d;          // current write number
   logic [1:0]  reg_sel_q, reg_sel_d;
   logic [4:0]  value_q, value_d;
   logic        do_reset_q, do_reset_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        romsel_q, romsel_d;
   logic        rw_q, rw_d;
   logic [14:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;

   logic        write_end;
   logic        write_phase;
   logic [2:0]  last_idx;
   logic [2:0]  bit_i;
   logic [7:0]  val_ext;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      reg_sel_d  = reg_sel_q;
      value_d    = value_q;
      do_reset_d = do_reset_q;
      done_d     = 1'b0;
      write_end  = 1'b0;
      last_idx   = do_reset_q ? 3'd5 : 3'd4;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               reg_sel_d  = reg_sel;
               value_d    = value;
               do_reset_d = do_reset;
               idx_d      = 3'd0;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = 4'd0;
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HOLD: begin
            if (GAP_LEN == 0) begin
               write_end = 1'b1;
            end else begin
               cnt_d   = 4'd0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               write_end = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (write_end) begin
         if (idx_q == last_idx) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SETUP;
         end
      end

      // Bus outputs are registered from the next state, so each output
      // changes exactly on the edge that enters the corresponding phase.
      write_phase = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                    (state_d == ST_HOLD);
      // With the reset prefix, write 0 is the 8'h80 write and data bits
      // start at write 1.
      bit_i   = do_reset_d ? (idx_d - 3'd1) : idx_d;
      val_ext = {3'b000, value_d};

      busy_d   = (state_d != ST_IDLE);
      romsel_d = (state_d != ST_STROBE);
      rw_d     = !write_phase;
      addr_d   = (state_d == ST_IDLE) ? 15'h0000 : {reg_sel_d, ADDR_LOW};
      if (!write_phase) begin
         data_d = 8'h00;
      end else if (do_reset_d && (idx_d == 3'd0)) begin
         data_d = 8'h80;
      end else begin
         data_d = {7'b0000000, val_ext[bit_i]};
      end
   end

   always_ff @(posedge m2) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= 3'd0;
         reg_sel_q  <= 2'd0;
         value_q    <= 5'd0;
         do_reset_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         romsel_q   <= 1'b1;
         rw_q       <= 1'b1;
         addr_q     <= 15'h0000;
         data_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         reg_sel_q  <= reg_sel_d;
         value_q    <= value_d;
         do_reset_q <= do_reset_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         romsel_q   <= romsel_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign romsel_out   = romsel_q;
   assign cpu_rw_out   = rw_q;
   assign cpu_addr_out = addr_q;
   assign cpu_data_out = data_q;

endmodule
